aes_dec_iter: RTL and testbench

- Iterative AES-128 decryption core; the inverse of the team's pipelined AES-128 encryptor.
- Accepts one 128-bit ciphertext and the original cipher key, and returns the plaintext after a fixed latency.
- Area-oriented: one inverse-round datapath is reused across 10 rounds, plus one key-schedule datapath.
- Derives the round-10 key on-chip (forward expansion), then walks the key schedule backwards while decrypting.
- Sits beside the encryptor in the crypto subsystem; the host drives a start/done handshake.

---
 rtl/aes_pkg.sv | 119 +++++++++++
 rtl/aes_inv_round.sv | 63 ++++++
 rtl/aes_dec_iter.sv | 161 ++++++++++++++++
 tb/tb_aes_dec_iter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
//   Shared definitions for the iterative AES-128 decryptor:
//     - FSM state encoding and round-count constants
//     - GF(2^8) helpers (xtime, gmul, x9/xB/xD/xE)
//     - forward / inverse S-box, computed as GF inverse plus affine map
//     - rcon lookup
//     - forward and inverse AES-128 key-schedule steps
//   Byte 0 of a 128-bit block sits in bits [127:120]; the state is
//   column-major, so byte index = 4*column + row.
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int AES_NR = 10;
    localparam int CNT_W  = 4;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(AES_NR);
    localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_KEYEXP = 2'd1,
        ST_ADDK   = 2'd2,
        ST_ROUND  = 2'd3
    } dec_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = xtime(aa);
        end
        return acc;
    endfunction

    function automatic logic [7:0] x9(input logic [7:0] b); return gmul(b, 8'h09); endfunction
    function automatic logic [7:0] xb(input logic [7:0] b); return gmul(b, 8'h0b); endfunction
    function automatic logic [7:0] xd(input logic [7:0] b); return gmul(b, 8'h0d); endfunction
    function automatic logic [7:0] xe(input logic [7:0] b); return gmul(b, 8'h0e); endfunction

    // Multiplicative inverse as a^254 (square-and-multiply); 0 maps to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] res;
        sq  = a;
        res = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            res = gmul(res, sq);
        end
        return res;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] b;
        b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    function automatic logic [7:0] rcon(input logic [CNT_W-1:0] i);
        logic [7:0] rc;
        case (i)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // k(i-1) -> k(i)
    function automatic logic [127:0] fwd_key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ {rc, 24'h0};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0]  ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // k(i) -> k(i-1); w3 is recovered first because w0 depends on it.
    function automatic logic [127:0] inv_key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0]  ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ sub_word(rot_word(w3)) ^ {rc, 24'h0};
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// ---------------------------------------------------------------------------
// aes_inv_round
//   Combinational AES inverse round:
//     st_o = InvMixColumns(InvSubBytes(InvShiftRows(st_i)) ^ rk_i)
//   with InvMixColumns bypassed when last_i is set (final round).
// Ports:
//   st_i   [127:0]  current state
//   rk_i   [127:0]  round key for this round
//   last_i          final round, skip InvMixColumns
//   st_o   [127:0]  next state
// ---------------------------------------------------------------------------
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] st_i,
    input  logic [127:0] rk_i,
    input  logic         last_i,
    output logic [127:0] st_o
);

    // Row r is rotated right by r columns: out[c][r] = in[(c - r) mod 4][r].
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int ro = 0; ro < 4; ro++) begin
                r[127-8*(4*c+ro) -: 8] = s[127-8*(4*((c-ro+4)%4)+ro) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [31:0]  col;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            col = s[127-32*c -: 32];
            r[127-32*c -: 32] = {
                xe(col[31:24]) ^ xb(col[23:16]) ^ xd(col[15:8]) ^ x9(col[7:0]),
                x9(col[31:24]) ^ xe(col[23:16]) ^ xb(col[15:8]) ^ xd(col[7:0]),
                xd(col[31:24]) ^ x9(col[23:16]) ^ xe(col[15:8]) ^ xb(col[7:0]),
                xb(col[31:24]) ^ xd(col[23:16]) ^ x9(col[15:8]) ^ xe(col[7:0])
            };
        end
        return r;
    endfunction

    logic [127:0] keyed;

    assign keyed = inv_sub_bytes(inv_shift_rows(st_i)) ^ rk_i;
    assign st_o  = last_i ? keyed : inv_mix_columns(keyed);

endmodule

// File: rtl/aes_dec_iter.sv
// ---------------------------------------------------------------------------
// aes_dec_iter
//   Iterative AES-128 decryptor. One inverse-round datapath and one
//   key-schedule datapath are reused: the round-10 key is first derived by
//   forward expansion (KEYEXP), then the schedule is walked backwards while
//   the ten inverse rounds run.
//   Flow: IDLE -> KEYEXP (10 clk) -> ADDK (1 clk) -> ROUND (10 clk) -> IDLE
//   done pulses 21 clocks after accept; OUT holds until the next accept.
//   A new start is refused during the done cycle, so busy drops for one
//   cycle between back-to-back blocks.
// Optional feature (macro AES_DEC_KEY_CACHE_EN):
//   caches {cipher key, k10}; an accept with the cached key skips KEYEXP
//   and finishes 11 clocks after accept.
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   IN    [127:0] ciphertext, sampled on accept
//   KEY   [127:0] cipher key, sampled on accept
//   start         request, accepted only when idle
//   busy          high from accept through the done cycle
//   done          one-cycle pulse, OUT valid
//   OUT   [127:0] plaintext
// ---------------------------------------------------------------------------
module aes_dec_iter
    import aes_pkg::*;
#(
    parameter int BLOCK_LENGTH = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BLOCK_LENGTH-1:0] IN,
    input  logic [BLOCK_LENGTH-1:0] KEY,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [BLOCK_LENGTH-1:0] OUT
);

    dec_state_e              state_q, state_d;
    logic [BLOCK_LENGTH-1:0] st_q;
    logic [BLOCK_LENGTH-1:0] rk_q;
    logic [BLOCK_LENGTH-1:0] out_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    done_q;

    logic                    accept;
    logic                    cache_hit;
    logic [BLOCK_LENGTH-1:0] key_load;
    logic [BLOCK_LENGTH-1:0] k_fwd;
    logic [BLOCK_LENGTH-1:0] k_prev;
    logic [BLOCK_LENGTH-1:0] round_out;

    // The done cycle is still part of the operation, hence the done_q term.
    assign accept = (state_q == ST_IDLE) && start && !done_q;

    assign k_fwd  = fwd_key_step(rk_q, rcon(cnt_q));
    assign k_prev = inv_key_step(rk_q, rcon(cnt_q));

    aes_inv_round u_inv_round (
        .st_i   (st_q),
        .rk_i   (k_prev),
        .last_i (cnt_q == CNT_FIRST),
        .st_o   (round_out)
    );

`ifdef AES_DEC_KEY_CACHE_EN
    logic [BLOCK_LENGTH-1:0] cached_key_q;
    logic [BLOCK_LENGTH-1:0] cached_k10_q;
    logic                    cache_valid_q;

    assign cache_hit = cache_valid_q && (KEY == cached_key_q);
    assign key_load  = cache_hit ? cached_k10_q : KEY;

    // The key is captured at accept and marked valid only once its k10 is
    // complete, so an aborted expansion never leaves a stale pairing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cached_key_q  <= '0;
            cached_k10_q  <= '0;
            cache_valid_q <= 1'b0;
        end else if (accept && !cache_hit) begin
            cached_key_q  <= KEY;
            cache_valid_q <= 1'b0;
        end else if (state_q == ST_KEYEXP && cnt_q == CNT_LAST) begin
            cached_k10_q  <= k_fwd;
            cache_valid_q <= 1'b1;
        end
    end
`else
    assign cache_hit = 1'b0;
    assign key_load  = KEY;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = cache_hit ? ST_ADDK : ST_KEYEXP;
            ST_KEYEXP: if (cnt_q == CNT_LAST) state_d = ST_ADDK;
            ST_ADDK:   state_d = ST_ROUND;
            ST_ROUND:  if (cnt_q == CNT_FIRST) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy = (state_q != ST_IDLE) || done_q;
        done = done_q;
        OUT  = out_q;
    end

    // Datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q   <= '0;
            rk_q   <= '0;
            out_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        st_q  <= IN;
                        rk_q  <= key_load;
                        cnt_q <= CNT_FIRST;
                    end
                end
                ST_KEYEXP: begin
                    rk_q  <= k_fwd;
                    cnt_q <= cnt_q + CNT_FIRST;
                end
                ST_ADDK: begin
                    st_q  <= st_q ^ rk_q;
                    cnt_q <= CNT_LAST;
                end
                ST_ROUND: begin
                    st_q  <= round_out;
                    rk_q  <= k_prev;
                    cnt_q <= cnt_q - CNT_FIRST;
                    if (cnt_q == CNT_FIRST) begin
                        out_q  <= round_out;
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_dec_iter.sv
// ---------------------------------------------------------------------------
// tb_aes_dec_iter
//   Self-checking bench for aes_dec_iter. Expected plaintexts come from a
//   table-driven AES-128 inverse cipher (full key expansion up front) and
//   from FIPS-197 vectors; expected latency comes from a small model of the
//   optional key cache (AES_DEC_KEY_CACHE_EN).
// ---------------------------------------------------------------------------
module tb_aes_dec_iter;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] IN;
    logic [127:0] KEY;
    logic         start;
    logic         busy;
    logic         done;
    logic [127:0] OUT;

    always #5 clk = ~clk;

    aes_dec_iter dut (
        .clk   (clk),
        .rst   (rst),
        .IN    (IN),
        .KEY   (KEY),
        .start (start),
        .busy  (busy),
        .done  (done),
        .OUT   (OUT)
    );

`ifdef AES_DEC_KEY_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]   sbox_t     [256];
    logic [7:0]   inv_sbox_t [256];
    bit           cache_v;
    logic [127:0] cache_k;
    logic [127:0] k10_seen;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 0; x = a; y = b;
        while (y != 0) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box via generator-3 walk: p runs over 3^k, q over 3^-k.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01; q = 8'h01;
        repeat (255) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
            sbox_t[p] = x;
        end
        sbox_t[0] = 8'h63;
        for (int i = 0; i < 256; i++) inv_sbox_t[sbox_t[i]] = 8'(i);
    endtask

    function automatic logic [127:0] model_dec(input logic [127:0] key, input logic [127:0] ct);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]} ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[40+c][31-8*r -: 8];
        for (int rd = 9; rd >= 0; rd--) begin
            t = s;
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[4*((c+r)%4)+r] = t[4*c+r];
            for (int i = 0; i < 16; i++) s[i] = inv_sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[4*rd+c][31-8*r -: 8];
            if (rd > 0) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gm(a0, 14) ^ gm(a1, 11) ^ gm(a2, 13) ^ gm(a3, 9);
                    s[4*c+1] = gm(a0, 9)  ^ gm(a1, 14) ^ gm(a2, 11) ^ gm(a3, 13);
                    s[4*c+2] = gm(a0, 13) ^ gm(a1, 9)  ^ gm(a2, 14) ^ gm(a3, 11);
                    s[4*c+3] = gm(a0, 11) ^ gm(a1, 13) ^ gm(a2, 9)  ^ gm(a3, 14);
                end
            end
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic int predict_lat(input logic [127:0] key);
        return (CACHE_EN && cache_v && key === cache_k) ? 11 : 21;
    endfunction

    // ---------------- stimulus helpers ----------------
    // Ends at the negedge right after the accepting edge.
    task automatic launch(input logic [127:0] key, input logic [127:0] ct, input bit hold);
        @(negedge clk);
        start = 1'b1; IN = ct; KEY = key;
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    // Counts edges until done; returns at the negedge inside the done cycle.
    task automatic wait_done(input string tag, input int exp_lat, input logic [127:0] exp_pt);
        int lat;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 10) k10_seen = dut.rk_q;
            if (done === 1'b1) begin lat = i; break; end
        end
        check({tag, "/latency"}, 128'(lat), 128'(exp_lat));
        check({tag, "/out"}, OUT, exp_pt);
    endtask

    task automatic run_vec(input string tag, input logic [127:0] key, input logic [127:0] ct);
        int el;
        el = predict_lat(key);
        launch(key, ct, 1'b0);
        check({tag, "/busy"}, 128'(busy), 128'(1));
        wait_done(tag, el, model_dec(key, ct));
        if (el == 21) begin cache_v = 1'b1; cache_k = key; end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [127:0] rk, rc;
        int           el, el2, n_done;

        build_sbox();
        cache_v = 1'b0; cache_k = '0;
        rst = 1'b0; start = 1'b0; IN = '0; KEY = '0;
        repeat (3) @(negedge clk);
        check("reset/out",  OUT, 128'h0);
        check("reset/busy", 128'(busy), 128'(0));
        check("reset/done", 128'(done), 128'(0));
        rst = 1'b1;

        // FIPS-197 App. B, with the internal k10 probe
        el = predict_lat(KEY_B);
        launch(KEY_B, CT_B, 1'b0);
        wait_done("appB", el, PT_B);
        check("appB/k10", k10_seen, K10_B);
        cache_v = 1'b1; cache_k = KEY_B;

        run_vec("appC1", KEY_C, CT_C);
        check("appC1/fips", OUT, PT_C);

        // random keys and blocks, some keys reused
        rk = {$urandom, $urandom, $urandom, $urandom};
        for (int t = 0; t < 6; t++) begin
            if (t % 3 != 2) rk = {$urandom, $urandom, $urandom, $urandom};
            rc = {$urandom, $urandom, $urandom, $urandom};
            run_vec($sformatf("rand%0d", t), rk, rc);
        end

        // same key twice, then a new key
        run_vec("repB1", KEY_B, CT_B);
        run_vec("repB2", KEY_B, CT_B);
        run_vec("repC", KEY_C, CT_C);

        // back-to-back with start held high
        el = predict_lat(KEY_B);
        launch(KEY_B, CT_B, 1'b1);
        wait_done("b2b1", el, PT_B);
        if (el == 21) begin cache_v = 1'b1; cache_k = KEY_B; end
        check("b2b/busy_done_cycle", 128'(busy), 128'(1));
        IN = CT_C; KEY = KEY_C;
        el2 = predict_lat(KEY_C);
        @(negedge clk);
        check("b2b/busy_gap", 128'(busy), 128'(0));
        @(negedge clk);
        check("b2b/busy_reaccept", 128'(busy), 128'(1));
        start = 1'b0;
        wait_done("b2b2", el2, PT_C);
        if (el2 == 21) begin cache_v = 1'b1; cache_k = KEY_C; end

        // start while busy is ignored
        el = predict_lat(KEY_B);
        launch(KEY_B, CT_B, 1'b0);
        repeat (4) @(negedge clk);
        start = 1'b1; IN = {$urandom, $urandom, $urandom, $urandom}; KEY = KEY_C;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore", el - 5, PT_B);
        if (el == 21) begin cache_v = 1'b1; cache_k = KEY_B; end

        // reset mid-operation
        launch(KEY_C, CT_C, 1'b0);
        repeat (15) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst/out",  OUT, 128'h0);
        check("midrst/busy", 128'(busy), 128'(0));
        check("midrst/done", 128'(done), 128'(0));
        cache_v = 1'b0;
        n_done = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 2) rst = 1'b1;
            if (done === 1'b1) n_done++;
        end
        check("midrst/no_done", 128'(n_done), 128'(0));
        run_vec("postrst", KEY_B, CT_B);
        run_vec("postrst2", KEY_B, CT_C);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
